// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared widths, blank code and width helper for the scan controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seven_seg_pkg;

    localparam int          DIGIT_W    = 4;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    // Ceiling log2; callers clamp the result to at least one bit.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/refresh_prescaler.sv
// ============================================================================
// Module   : refresh_prescaler
// Purpose  : Free-running 0..REFRESH_DIV-1 counter; tick marks terminal count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module refresh_prescaler
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int              CNT_W      = (REFRESH_DIV > 1) ? clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        tick    = (count_q == LAST_COUNT);
        count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seven_segment_scan_controller.sv
// ============================================================================
// Module   : seven_segment_scan_controller
// Purpose  : Double-buffered multiplexed scan of a packed BCD value onto a
//            per-digit-anode display. Optional LEADING_ZERO_BLANK_EN blanks
//            leading zero digits above digit 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seven_segment_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value_bcd,
    input  logic [NUM_DIGITS-1:0]         dp_n_mask,
    input  logic                          update_valid,
    output logic                          update_ready,
    output logic [DIGIT_W-1:0]            digit_to_be_displayed,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic                          frame_tick
);

    localparam int               SLOT_W    = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam int               VAL_W     = DIGIT_W * NUM_DIGITS;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);

    logic                  slot_tick;
    logic                  frame_end;
    logic                  xfer;
    logic [NUM_DIGITS-1:0] blank_mask;

    logic [SLOT_W-1:0]     slot_q,       slot_d;
    logic                  pend_full_q,  pend_full_d;
    logic [VAL_W-1:0]      pend_val_q,   pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q,    pend_dp_d;
    logic [VAL_W-1:0]      disp_val_q,   disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q,    disp_dp_d;
    logic [NUM_DIGITS-1:0] anode_n_q,    anode_n_d;
    logic [DIGIT_W-1:0]    digit_q,      digit_d;
    logic                  dp_q,         dp_d;
    logic                  frame_tick_q, frame_tick_d;

    refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (slot_tick)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the most significant digit; blank while everything seen so far is zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (disp_val_q[i*DIGIT_W +: DIGIT_W] == '0);
            if (i > 0) begin
                blank_mask[i] = upper_zero;
            end
        end
    end
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        frame_end = slot_tick && (slot_q == LAST_SLOT);
        xfer      = update_valid && !pend_full_q;

        slot_d = slot_q;
        if (slot_tick) begin
            slot_d = frame_end ? '0 : slot_q + 1'b1;
        end

        pend_full_d = pend_full_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;

        // A full pending buffer blocks xfer, so the commit and capture never collide.
        if (frame_end && pend_full_q) begin
            disp_val_d  = pend_val_q;
            disp_dp_d   = pend_dp_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_val_d  = value_bcd;
            pend_dp_d   = dp_n_mask;
            pend_full_d = 1'b1;
        end

        anode_n_d = '1;
        digit_d   = BLANK_CODE;
        dp_d      = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (SLOT_W'(i) == slot_q) begin
                anode_n_d[i] = 1'b0;
                digit_d      = blank_mask[i] ? BLANK_CODE : disp_val_q[i*DIGIT_W +: DIGIT_W];
                dp_d         = disp_dp_q[i];
            end
        end

        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_q       <= '0;
            pend_full_q  <= 1'b0;
            pend_val_q   <= '0;
            pend_dp_q    <= '1;
            disp_val_q   <= {NUM_DIGITS{BLANK_CODE}};
            disp_dp_q    <= '1;
            anode_n_q    <= '1;
            digit_q      <= BLANK_CODE;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            pend_full_q  <= pend_full_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            anode_n_q    <= anode_n_d;
            digit_q      <= digit_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign update_ready          = !pend_full_q;
    assign digit_to_be_displayed = digit_q;
    assign dp                    = dp_q;
    assign anode_n               = anode_n_q;
    assign frame_tick            = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scan_controller.sv
// ============================================================================
// Module   : tb_seven_segment_scan_controller
// Purpose  : Directed plus randomized bench against a cycle-count reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seven_segment_scan_controller;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic        clk;
    logic        reset_n;
    logic [15:0] value_bcd;
    logic [3:0]  dp_n_mask;
    logic        update_valid;
    logic        update_ready;
    logic [3:0]  digit_to_be_displayed;
    logic        dp;
    logic [3:0]  anode_n;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: cycle count since reset release plus the two buffers.
    int          m_cyc;
    bit          m_full;
    bit          m_xfer;
    logic [15:0] m_pend, m_disp;
    logic [3:0]  m_pend_dp, m_disp_dp;
    logic [3:0]  e_anode, e_digit;
    logic        e_dp, e_ft, e_ready;

    seven_segment_scan_controller #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .value_bcd             (value_bcd),
        .dp_n_mask             (dp_n_mask),
        .update_valid          (update_valid),
        .update_ready          (update_ready),
        .digit_to_be_displayed (digit_to_be_displayed),
        .dp                    (dp),
        .anode_n               (anode_n),
        .frame_tick            (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, m_cyc, $time);
        end
    endtask

    function automatic logic [3:0] shown(input logic [15:0] val, input int slot);
        logic [15:0] upper;
        upper = val >> (4 * slot);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && upper == 16'h0) return 4'hF;
`endif
        return upper[3:0];
    endfunction

    // Predict the edge from the current inputs, clock it, then compare.
    task automatic step();
        int slot;
        bit fb;
        m_xfer = 1'b0;
        if (!reset_n) begin
            m_cyc     = 0;
            m_full    = 1'b0;
            m_disp    = 16'hFFFF;
            m_disp_dp = 4'hF;
            e_anode   = 4'hF;
            e_digit   = 4'hF;
            e_dp      = 1'b1;
            e_ft      = 1'b0;
        end else begin
            slot    = (m_cyc / DIV) % N;
            fb      = (m_cyc % FRAME) == FRAME - 1;
            e_anode = ~(4'b0001 << slot);
            e_digit = shown(m_disp, slot);
            e_dp    = m_disp_dp[slot];
            e_ft    = fb;
            m_xfer  = update_valid && !m_full;
            if (fb && m_full) begin
                m_disp    = m_pend;
                m_disp_dp = m_pend_dp;
                m_full    = 1'b0;
            end
            if (m_xfer) begin
                m_pend    = value_bcd;
                m_pend_dp = dp_n_mask;
                m_full    = 1'b1;
            end
            m_cyc++;
        end
        e_ready = !m_full;
        @(posedge clk);
        #1;
        check("anode_n",      16'(anode_n),               16'(e_anode));
        check("digit",        16'(digit_to_be_displayed), 16'(e_digit));
        check("dp",           16'(dp),                    16'(e_dp));
        check("frame_tick",   16'(frame_tick),            16'(e_ft));
        check("update_ready", 16'(update_ready),          16'(e_ready));
    endtask

    // Offer a value and hold it until accepted (bounded).
    task automatic offer(input logic [15:0] val, input logic [3:0] dpm);
        bit accepted;
        accepted     = 1'b0;
        value_bcd    = val;
        dp_n_mask    = dpm;
        update_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME && !accepted; i++) begin
            step();
            accepted = m_xfer;
        end
        if (!accepted) check("offer_timeout", 16'(accepted), 16'h1);
        update_valid = 1'b0;
    endtask

    task automatic wait_frame_pos(input int pos);
        for (int i = 0; i < 2 * FRAME && (m_cyc % FRAME) != pos; i++) step();
        check("frame_pos_reached", 16'(m_cyc % FRAME), 16'(pos));
    endtask

    initial begin
        reset_n      = 1'b0;
        update_valid = 1'b0;
        value_bcd    = 16'h0;
        dp_n_mask    = 4'hF;
        m_cyc        = 0;
        m_full       = 1'b0;
        m_pend       = 16'h0;
        m_pend_dp    = 4'hF;
        m_disp       = 16'hFFFF;
        m_disp_dp    = 4'hF;

        repeat (5) step();
        reset_n = 1'b1;

        offer(16'h1234, 4'b1011);
        repeat (2 * FRAME + 4) step();

        // Backpressure: 5678 waits behind 4321 until the pending buffer drains.
        offer(16'h4321, 4'b1111);
        offer(16'h5678, 4'b0110);
        repeat (2 * FRAME) step();

        // Transfer on the frame-boundary cycle with pending empty.
        wait_frame_pos(FRAME - 1);
        check("pending_empty_at_boundary", 16'(update_ready), 16'h1);
        offer(16'h9012, 4'b1101);
        repeat (2 * FRAME + 2) step();

        // Reset in slot 2 with pending full; the pending value must never show.
        wait_frame_pos(0);
        offer(16'h3333, 4'b0000);
        for (int i = 0; i < FRAME && ((m_cyc / DIV) % N) != 2; i++) step();
        check("pending_full_at_slot2", 16'(update_ready), 16'h0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (2 * FRAME) step();

        offer(16'h0070, 4'b1111);
        repeat (2 * FRAME + 2) step();

        // Randomized traffic with occasional resets; data held while unaccepted.
        for (int c = 0; c < 600; c++) begin
            if (!update_valid || m_xfer) begin
                logic [15:0] v;
                for (int k = 0; k < 4; k++) begin
                    v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                end
                value_bcd    = v;
                dp_n_mask    = 4'($urandom_range(0, 15));
                update_valid = ($urandom_range(0, 3) == 0);
            end
            reset_n = ($urandom_range(0, 149) != 0);
            step();
        end
        reset_n      = 1'b1;
        update_valid = 1'b0;
        repeat (FRAME) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seven_segment_scan_controller.md
Name: seven_segment_scan_controller

Overview:
- Time-multiplexes an NUM_DIGITS-digit packed BCD value onto a common-segment, per-digit-anode display.
- Sits directly upstream of the seven-segment decoder, driving its digit_to_be_displayed and dp inputs one digit slot at a time, plus the active-low anode enables.
- Double-buffers the displayed value behind a valid/ready handshake. New values are committed only at frame boundaries, so no frame ever mixes old and new digits.

Parameters:
- NUM_DIGITS, 4, number of digit slots and anodes; must be >= 1.
- REFRESH_DIV, 50000, clk cycles per digit slot; must be >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- value_bcd  input  4*NUM_DIGITS  packed BCD; nibble i ([4i+3:4i]) is digit i, digit 0 least significant.
- dp_n_mask  input  NUM_DIGITS  bit i drives dp of digit i, active-low (0 lights the dp).
- update_valid  input  1  upstream offers value_bcd/dp_n_mask.
- update_ready  output  1  pending buffer empty; transfer occurs when valid && ready.
- digit_to_be_displayed  output  4  BCD code for the current slot, to the decoder.
- dp  output  1  dp for the current slot, to the decoder.
- anode_n  output  NUM_DIGITS  one-hot-low anode enable; bit i low selects digit i.
- frame_tick  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (reset_n low at a clk edge) values:
  - Prescaler 0, slot 0, pending buffer empty.
  - Display buffer all nibbles 4'hF, dp mask all ones.
  - Outputs: update_ready=1, digit_to_be_displayed=4'hF, dp=1, anode_n all ones, frame_tick=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. At terminal count (TC) the slot index advances 0..NUM_DIGITS-1 and wraps to 0.
- Frame boundary is TC while slot==NUM_DIGITS-1.
- Outputs are registered from the slot index and display buffer with 1-cycle latency:
  - The first cycle after reset release loads slot 0.
  - anode_n, digit and dp always change together on the same edge.
- Handshake:
  - Transfer happens on a cycle where update_valid && update_ready: value_bcd and dp_n_mask are captured into the pending buffer, and update_ready is 0 from the next cycle.
  - update_valid while update_ready=0 is ignored; upstream must hold its data.
  - At a frame boundary with the pending buffer full, pending is copied to the display buffer and pending is emptied. frame_tick=1 and update_ready=1 appear on the following cycle.
  - At a frame boundary with pending empty, the display buffer is unchanged and frame_tick still pulses.
- Simultaneous transfer and frame boundary with pending empty: the value is captured into pending only. It is displayed after the next frame boundary, with no bypass.
- Non-BCD nibbles (A-F) pass through unmodified; the decoder blanks them.
- NUM_DIGITS=1: every TC is a frame boundary and anode_n is held at 0 after reset.
- REFRESH_DIV=1: the slot advances every cycle.
- Reset mid-frame: pending data is discarded and the display reverts to blank. Scanning restarts at slot 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined: on output, each digit i>0 is replaced by 4'hF if it and all more-significant digits are 0. dp is not affected. Digit 0 is never blanked.
- When undefined: all digits are shown as stored.

Decomposition:
- Package seven_seg_pkg holds:
  - DIGIT_W=4 and BLANK_CODE=4'hF.
  - A clog2 function for the slot and prescaler widths.
- One sub-module, refresh_prescaler (parameter REFRESH_DIV; ports clk, reset_n, tick). It is instantiated once for the slot-advance tick.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
1. Reset: reset_n low 5 cycles -> anode_n=4'b1111, digit=4'hF, dp=1, update_ready=1, frame_tick=0.
2. Load: after reset, valid with value_bcd=16'h1234, dp_n_mask=4'b1011.
   - Response: update_ready drops next cycle, then frame_tick and ready rise together.
   - Next frame: digits 4,3,2,1 with anode_n 1110,1101,1011,0111, 4 cycles each; dp=0 only in slot 2.
3. Backpressure: hold valid with 16'h5678 while ready=0 -> not captured; captured on the first ready=1 cycle; 1234 is shown until the following frame boundary.
4. Coincidence: transfer on the same cycle as a frame boundary (pending empty) -> the old value is shown for one more full frame (16 cycles), the new value after that.
5. Reset mid-frame at slot 2 with pending full -> blank outputs next cycle, ready=1, the pending value is never displayed.
6. Load 16'h0070:
   - With LEADING_ZERO_BLANK_EN: slots show 0,7,F,F.
   - Without it: slots show 0,7,0,0.
